// File: rtl/cfg_loader_pkg.sv
// Shared constants, state encoding and small helpers for the configuration-frame loader.
package cfg_loader_pkg;

  localparam logic [31:0] SYNC_WORD = 32'hFAB0_C0DE;
  localparam int          LAST_BIT  = 31;
  localparam int          ADDR_LSB  = 0;
  localparam int          ADDR_MSB  = 15;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    WRITE,
    CHK,
    DONE,
    ERROR
  } state_e;

  function automatic logic ready_in(input state_e st);
    return (st == IDLE) || (st == ADDR) || (st == DATA) || (st == CHK);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cfg_frame_decoder.sv
// Binary frame index plus enable to one-hot column frame strobe.
module cfg_frame_decoder
  import cfg_loader_pkg::*;
#(
  parameter int NUM_FRAMES = 20
) (
  input  logic [ADDR_MSB:ADDR_LSB] idx_i,
  input  logic                     en_i,
  output logic [NUM_FRAMES-1:0]    onehot_o
);

  always_comb begin
    onehot_o = '0;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      if (en_i && (idx_i == 16'(i))) onehot_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/cfg_frame_loader.sv
// Streams SYNC / ADDR,DATA pairs / CHK words into per-column configuration latches
// with XOR checksum validation and sticky done/error status.
module cfg_frame_loader
  import cfg_loader_pkg::*;
#(
  parameter int FRAME_BITS = 32,
  parameter int NUM_FRAMES = 20
) (
  input  logic                  prog_clk,
  input  logic                  prog_reset,
  input  logic [31:0]           s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic [NUM_FRAMES-1:0] frame_strobe,
  output logic [15:0]           frames_written,
  output logic                  cfg_done,
  output logic                  cfg_error
);

  state_e                  state_q, state_d;
  logic                    s_ready_q;
  logic [15:0]             idx_q;
  logic                    last_q;
  logic [31:0]             csum_q;
  logic [FRAME_BITS-1:0]   frame_data_q;
  logic [NUM_FRAMES-1:0]   strobe_q;
  logic [NUM_FRAMES-1:0]   dec_onehot;
  logic [15:0]             fw_q;
  logic                    done_q;
  logic                    err_q;

  logic                    accept;
  logic [15:0]             addr_w;
  logic                    addr_bad;

  assign accept   = s_valid & s_ready_q;
  assign addr_w   = s_data[ADDR_MSB:ADDR_LSB];
  assign addr_bad = (addr_w >= 16'(NUM_FRAMES));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && (s_data == SYNC_WORD)) state_d = ADDR;
      ADDR:    if (accept) state_d = addr_bad ? ERROR : DATA;
      DATA:    if (accept) state_d = WRITE;
      WRITE:   state_d = last_q ? CHK : ADDR;
      CHK:     if (accept) state_d = (s_data == csum_q) ? DONE : ERROR;
      default: state_d = state_q;
    endcase
  end

  // Strobe is registered at the DATA-accept edge so it is high exactly during WRITE.
  cfg_frame_decoder #(.NUM_FRAMES(NUM_FRAMES)) u_dec (
    .idx_i   (idx_q),
    .en_i    ((state_q == DATA) && accept),
    .onehot_o(dec_onehot)
  );

  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b1;
      idx_q        <= '0;
      last_q       <= 1'b0;
      csum_q       <= '0;
      frame_data_q <= '0;
      strobe_q     <= '0;
      fw_q         <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= ready_in(state_d);
      strobe_q  <= dec_onehot;
      done_q    <= done_q | (state_d == DONE);
      err_q     <= err_q | (state_d == ERROR);
      case (state_q)
        IDLE: begin
          if (accept && (s_data == SYNC_WORD)) begin
            csum_q <= '0;
            fw_q   <= '0;
          end
        end
        ADDR: begin
          if (accept && !addr_bad) begin
            idx_q  <= addr_w;
            last_q <= s_data[LAST_BIT];
            csum_q <= csum_q ^ s_data;
          end
        end
        DATA: begin
          if (accept) begin
            frame_data_q <= s_data[FRAME_BITS-1:0];
            csum_q       <= csum_q ^ s_data;
          end
        end
        WRITE:   fw_q <= sat_inc16(fw_q);
        default: ;
      endcase
    end
  end

  // Reset wins over a strobe already in flight: the latch write is masked in the reset cycle.
  assign frame_strobe   = prog_reset ? '0 : strobe_q;
  assign s_ready        = s_ready_q;
  assign frame_data     = frame_data_q;
  assign frames_written = fw_q;
  assign cfg_done       = done_q;
  assign cfg_error      = err_q;

endmodule

// File: doc/cfg_frame_loader.md
# cfg_frame_loader

Configuration-frame loader for the eFPGA fabric: accepts a 32-bit word stream from the host-side programming port, checks framing and checksum, and writes configuration frames into the fabric's per-column configuration latches. These latches drive the select inputs of the routing and LUT multiplexers. The loader is the writer end of that select path: the fabric consumes static select bits, and this block produces them. It sits between the programming interface and the column frame-strobe lines of the 20x20 array.

## Interface
- `FRAME_BITS`, 32: configuration bits per frame; legal range 1..32; uses `s_data[FRAME_BITS-1:0]`.
- `NUM_FRAMES`, 20: number of addressable frames (one strobe line each).
- `prog_clk` input, 1: programming clock. One clock only.
- `prog_reset` input, 1: reset, synchronous and active-high.
- `s_data` input, 32: stream word.
- `s_valid` input, 1: `s_data` is valid.
- `s_ready` output, 1: loader accepts a word this cycle. Transfer occurs when `s_valid & s_ready` at the rising edge.
- `frame_data` output, FRAME_BITS: frame contents, held between writes.
- `frame_strobe` output, NUM_FRAMES: one-hot write enable, one cycle.
- `frames_written` output, 16: count of frames written since the last SYNC.
- `cfg_done` output, 1: load completed and checksum matched (sticky).
- `cfg_error` output, 1: bad address or checksum mismatch (sticky).

## Operation
- Stream format:
  - SYNC word `32'hFAB0_C0DE`.
  - Then pairs of ADDR and DATA words:
    - ADDR `[15:0]` = frame index.
    - ADDR `[31]` = LAST.
    - ADDR `[30:16]` ignored.
  - Then one CHK word.
- States:
  - IDLE: `s_ready`=1. Non-SYNC words are dropped silently. On SYNC: go to ADDR, clear checksum and `frames_written`.
  - ADDR: `s_ready`=1.
    - Index ≥ NUM_FRAMES → ERROR.
    - Otherwise latch the index and the LAST flag, XOR the word into the checksum, and go to DATA.
  - DATA: `s_ready`=1. Latch `s_data[FRAME_BITS-1:0]` into `frame_data`, XOR the full word into the checksum, and go to WRITE.
  - WRITE: `s_ready`=0. `frame_strobe[idx]`=1 for exactly this cycle. Increment `frames_written`, which saturates at 16'hFFFF. Next state is CHK if LAST was set, else ADDR.
  - CHK: `s_ready`=1.
    - Word equals the running checksum → DONE.
    - Otherwise → ERROR.
  - DONE: `s_ready`=0, `cfg_done`=1. Terminal until `prog_reset`.
  - ERROR: `s_ready`=0, `cfg_error`=1, no strobes. Terminal until `prog_reset`.
- Checksum: 32-bit XOR of every ADDR and DATA word after SYNC; the SYNC and CHK words are excluded.
- Frames already strobed before an error keep their contents. The loader never clears latches.
- Writing the same index twice is legal; the last write wins.
- LAST on the first pair gives a single-frame load.

## Timing
- Reset values:
  - state = IDLE, `s_ready`=1.
  - `frame_data`=0, `frame_strobe`=0, `frames_written`=0.
  - `cfg_done`=0, `cfg_error`=0.
- A DATA word accepted at edge N gives `frame_strobe` high during cycle N+1, with `frame_data` already valid that cycle. `frame_data` is stable the whole strobe cycle and afterwards.
- `frames_written` updates at the edge that ends the WRITE cycle.
- Maximum throughput is 3 cycles per frame: ADDR, DATA, WRITE.
- `s_valid` low stalls any accepting state indefinitely. No timeout.
- `prog_reset` asserted mid-load, including during WRITE, behaves as follows:
  - Next cycle, the reset values above apply.
  - A strobe in the reset cycle is suppressed; reset has priority.
- `s_ready` is a registered function of state only, with no combinational path from `s_valid`.
- `cfg_done`/`cfg_error` assert in the cycle after the CHK word is accepted, or after the bad ADDR word is accepted.

## Structure
- Package `cfg_loader_pkg` holds:
  - `SYNC_WORD`.
  - `LAST_BIT`=31.
  - `ADDR_LSB`/`ADDR_MSB`=0/15.
  - The state enum: IDLE, ADDR, DATA, WRITE, CHK, DONE, ERROR.
- Sub-module `cfg_frame_decoder` converts the binary index plus an enable into the NUM_FRAMES one-hot strobe. The bench reuses it as the reference model.

## Test plan
- Garbage 32'h1234_5678, then SYNC; ADDR 0; DATA 32'hA5A5_A5A5; ADDR 32'h8000_0013; DATA 32'h0000_00FF; CHK = XOR of those four words → expected:
  - `frame_strobe` = bit0, then bit19.
  - `frames_written`=2, `cfg_done`=1, `s_ready`=0.
- SYNC, ADDR 20 → `cfg_error`=1 the next cycle, no strobe ever, `s_ready`=0.
- Valid 3-frame load with CHK off by one bit → all 3 strobes fire, then `cfg_error`=1 and `cfg_done`=0.
- Back-to-back `s_valid` for 5 frames → strobes 3 cycles apart, each `frame_data` equals its DATA word.
- Random `s_valid` gaps → strobe order and data unchanged.
- `prog_reset` asserted in the WRITE cycle of frame 2 → that strobe is suppressed and all outputs return to reset values. A fresh SYNC load then completes with `cfg_done`=1.
